dma_cmd_mem_responder: RTL



---
 rtl/dma_resp_pkg.sv | 13 +
 rtl/dma_resp_fifo.sv | 50 +++++
 rtl/dma_cmd_mem_responder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dma_resp_pkg.sv
// rtl/dma_resp_pkg.sv - shared constants for the DMA command memory responder
package dma_resp_pkg;

  localparam int CMD_ADDR_W = 26;
  localparam int HDR_ADDR_W = 24;
  localparam int STAT_W     = 32;

  localparam logic [1:0] STAT_WR_BURSTS  = 2'd0;
  localparam logic [1:0] STAT_RD_BURSTS  = 2'd1;
  localparam logic [1:0] STAT_ERR_COUNT  = 2'd2;
  localparam logic [1:0] STAT_FIFO_COUNT = 2'd3;

endpackage

// File: rtl/dma_resp_fifo.sv
// rtl/dma_resp_fifo.sv - registered-count synchronous FIFO buffering read responses
module dma_resp_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_tvalid,
  input  logic [WIDTH-1:0] push_tdata,
  output logic             pop_tvalid,
  output logic [WIDTH-1:0] pop_tdata,
  input  logic             pop_tready,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full;
  logic             pop_fire;
  logic             push_fire;

  assign full       = (count_q == CW'(DEPTH));
  assign pop_tvalid = (count_q != '0);
  assign pop_fire   = pop_tvalid && pop_tready;
  // A push into a full FIFO is still taken when the head leaves in the same cycle.
  assign push_fire  = push_tvalid && (!full || pop_fire);
  assign pop_tdata  = buf_q[rd_ptr_q];
  assign count      = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_fire) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_fire)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_fire) - CW'(pop_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) buf_q[wr_ptr_q] <= push_tdata;
  end

endmodule

// File: rtl/dma_cmd_mem_responder.sv
// rtl/dma_cmd_mem_responder.sv - DMA command memory responder; DMA_RESP_ADDR_CHECK_EN adds range checks
module dma_cmd_mem_responder
  import dma_resp_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_BYTES  = 65536,
  parameter int HDR_BYTES  = 4096,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dma_cmd_wr_en,
  input  logic [CMD_ADDR_W-1:0] dma_cmd_wr_addr,
  input  logic [DATA_WIDTH-1:0] dma_cmd_wr_data,
  input  logic [STRB_WIDTH-1:0] dma_cmd_wr_strb,
  input  logic                  dma_cmd_wr_last,
  input  logic                  dma_cmd_hdr_wr_en,
  input  logic [HDR_ADDR_W-1:0] dma_cmd_hdr_wr_addr,
  output logic                  dma_cmd_wr_ready,
  input  logic                  dma_cmd_rd_en,
  input  logic [CMD_ADDR_W-1:0] dma_cmd_rd_addr,
  input  logic                  dma_cmd_rd_last,
  output logic                  dma_cmd_rd_ready,
  output logic                  dma_rd_resp_valid,
  output logic [DATA_WIDTH-1:0] dma_rd_resp_data,
  input  logic                  dma_rd_resp_ready,
  input  logic [1:0]            stat_addr,
  output logic [STAT_W-1:0]     stat_data
);

  localparam int SW        = $clog2(STRB_WIDTH);
  localparam int MEM_AW    = $clog2(MEM_BYTES);
  localparam int HDR_AW    = $clog2(HDR_BYTES);
  localparam int MEM_WORDS = MEM_BYTES / STRB_WIDTH;
  localparam int HDR_WORDS = HDR_BYTES / STRB_WIDTH;
  localparam int CW        = $clog2(RESP_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  // Header copy has no read port here; its consumer reads it elsewhere.
  logic [DATA_WIDTH-1:0] unused_hdr_ram [HDR_WORDS];

  logic [MEM_AW-SW-1:0]  wr_idx, rd_idx;
  logic [HDR_AW-SW-1:0]  hdr_idx;
  logic                  wr_ready_q, rd_pend_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [CW-1:0]         fifo_count;
  logic [STAT_W-1:0]     wr_bursts_q, rd_bursts_q, err_count;
  logic                  wr_fire, hdr_fire, rd_fire;
  logic                  wr_bad, hdr_bad, rd_bad;
  logic                  unused_addr_bits;

  assign wr_idx  = dma_cmd_wr_addr[MEM_AW-1:SW];
  assign rd_idx  = dma_cmd_rd_addr[MEM_AW-1:SW];
  assign hdr_idx = dma_cmd_hdr_wr_addr[HDR_AW-1:SW];
  assign unused_addr_bits = ^{dma_cmd_wr_addr, dma_cmd_rd_addr, dma_cmd_hdr_wr_addr};

  assign dma_cmd_wr_ready = wr_ready_q;
  assign wr_fire  = dma_cmd_wr_en && wr_ready_q;
  assign hdr_fire = wr_fire && dma_cmd_hdr_wr_en;
  // Only registered occupancy feeds rd_ready, so resp_ready never reaches it combinationally.
  assign dma_cmd_rd_ready = wr_ready_q &&
      ((32'(fifo_count) + 32'(rd_pend_q)) < 32'(RESP_DEPTH));
  assign rd_fire = dma_cmd_rd_en && dma_cmd_rd_ready;

`ifdef DMA_RESP_ADDR_CHECK_EN
  logic [STAT_W-1:0] err_count_q;
  logic [1:0]        err_inc;

  assign wr_bad  = 32'(dma_cmd_wr_addr) >= 32'(MEM_BYTES);
  assign hdr_bad = 32'(dma_cmd_hdr_wr_addr) >= 32'(HDR_BYTES);
  assign rd_bad  = 32'(dma_cmd_rd_addr) >= 32'(MEM_BYTES);
  assign err_inc = 2'(wr_fire && wr_bad) + 2'(hdr_fire && hdr_bad) + 2'(rd_fire && rd_bad);
  assign err_count = err_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_count_q <= '0;
    else        err_count_q <= err_count_q + STAT_W'(err_inc);
  end
`else
  assign wr_bad    = 1'b0;
  assign hdr_bad   = 1'b0;
  assign rd_bad    = 1'b0;
  assign err_count = '0;
`endif

  // Nonblocking RAM write keeps same-cycle reads on the old contents.
  always_ff @(posedge clk) begin
    if (rd_fire) rd_data_q <= rd_bad ? '0 : mem[rd_idx];
    for (int b = 0; b < STRB_WIDTH; b++) begin
      if (wr_fire && !wr_bad && dma_cmd_wr_strb[b])
        mem[wr_idx][b*8 +: 8] <= dma_cmd_wr_data[b*8 +: 8];
      if (hdr_fire && !hdr_bad && dma_cmd_wr_strb[b])
        unused_hdr_ram[hdr_idx][b*8 +: 8] <= dma_cmd_wr_data[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ready_q  <= 1'b0;
      rd_pend_q   <= 1'b0;
      wr_bursts_q <= '0;
      rd_bursts_q <= '0;
    end else begin
      wr_ready_q <= 1'b1;
      rd_pend_q  <= rd_fire;
      if (wr_fire && dma_cmd_wr_last) wr_bursts_q <= wr_bursts_q + STAT_W'(1);
      if (rd_fire && dma_cmd_rd_last) rd_bursts_q <= rd_bursts_q + STAT_W'(1);
    end
  end

  dma_resp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_tvalid (rd_pend_q),
    .push_tdata  (rd_data_q),
    .pop_tvalid  (dma_rd_resp_valid),
    .pop_tdata   (dma_rd_resp_data),
    .pop_tready  (dma_rd_resp_ready),
    .count       (fifo_count)
  );

  always_comb begin
    stat_data = '0;
    case (stat_addr)
      STAT_WR_BURSTS:  stat_data = wr_bursts_q;
      STAT_RD_BURSTS:  stat_data = rd_bursts_q;
      STAT_ERR_COUNT:  stat_data = err_count;
      STAT_FIFO_COUNT: stat_data = STAT_W'(fifo_count);
      default:         stat_data = '0;
    endcase
  end

endmodule
